// File: rtl/dco_ctrl_pkg.sv
// Shared types and helpers for the DCO frequency-locking trim controller.
package dco_ctrl_pkg;

    localparam int unsigned TRIM_N_DEF = 26;
    localparam int unsigned CODE_W     = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    // Thermometer expansion: bit i is set when i < code.
    function automatic logic [TRIM_N_DEF-1:0] therm(input logic [CODE_W-1:0] code);
        logic [TRIM_N_DEF-1:0] v;
        v = '0;
        for (int i = 0; i < int'(TRIM_N_DEF); i++) begin
            v[i] = (i < int'(code));
        end
        return v;
    endfunction

endpackage

// File: rtl/dco_trim_controller_if.sv
// Control/trim bundle between the DCO trim controller and its environment.
interface dco_trim_if #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned TRIM_N = dco_ctrl_pkg::TRIM_N_DEF
);

    logic                            enable;
    logic                            ref_clk;
    logic [CNT_W-1:0]                div;
    logic [TRIM_N-1:0]               trim;
    logic [dco_ctrl_pkg::CODE_W-1:0] trim_code;
    logic                            locked;

    modport master (
        output enable, ref_clk, div,
        input  trim, trim_code, locked
    );

    modport slave (
        input  enable, ref_clk, div,
        output trim, trim_code, locked
    );

endinterface

// File: rtl/ref_edge_sync.sv
// Brings the asynchronous reference into the DCO domain and emits a
// one-cycle registered pulse on each synchronized rising edge.
module ref_edge_sync (
    input  logic clock,
    input  logic resetb,
    input  logic ref_clk,
    output logic ref_rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            prev_q   <= 1'b0;
            ref_rise <= 1'b0;
        end else begin
            meta_q   <= ref_clk;
            sync_q   <= meta_q;
            prev_q   <= sync_q;
            ref_rise <= sync_q & ~prev_q;
        end
    end

endmodule

// File: rtl/dco_trim_controller.sv
// Frequency-locking loop: counts DCO cycles per reference period and steps a
// thermometer trim word until the count matches the programmed divide ratio.
module dco_trim_controller
    import dco_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TRIM_N    = TRIM_N_DEF,
    parameter int unsigned INIT_CODE = 13,
    parameter int unsigned LOCK_TOL  = 1,
    parameter int unsigned LOCK_CNT  = 4
) (
    input logic       clock,
    input logic       resetb,
    dco_trim_if.slave bus
);

    localparam int unsigned CMP_W = CNT_W + 1;
    localparam int unsigned LCK_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CODE_W-1:0] CODE_MAX  = CODE_W'(TRIM_N);
    localparam logic [CODE_W-1:0] CODE_INIT = CODE_W'(INIT_CODE);
    localparam logic [CMP_W-1:0]  TOL       = CMP_W'(LOCK_TOL);
    localparam logic [LCK_W-1:0]  LCK_FULL  = LCK_W'(LOCK_CNT);
    localparam logic [LCK_W-1:0]  LCK_LAST  = LCK_W'(LOCK_CNT - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CODE_W-1:0] code;
    logic [TRIM_N-1:0] trim_q;
    logic [LCK_W-1:0]  lock_cnt;
    logic              locked_q;
    logic              ref_rise;

    logic [CNT_W-1:0]  cnt_inc_c;
    logic [CMP_W-1:0]  meas_c;
    logic [CMP_W-1:0]  div_c;
    logic [CMP_W-1:0]  div_hi_c;
    logic [CMP_W-1:0]  div_lo_c;
    logic              too_fast_c;
    logic              too_slow_c;
    logic [CODE_W-1:0] code_up_c;
    logic [CODE_W-1:0] code_dn_c;

    ref_edge_sync u_ref_sync (
        .clock    (clock),
        .resetb   (resetb),
        .ref_clk  (bus.ref_clk),
        .ref_rise (ref_rise)
    );

    // Window classification; the counter value at ref_rise is the measurement.
    always_comb begin
        cnt_inc_c  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        meas_c     = {1'b0, cnt};
        div_c      = {1'b0, bus.div};
        div_hi_c   = div_c + TOL;
        div_lo_c   = (div_c > TOL) ? div_c - TOL : '0;
        too_fast_c = (cnt == CNT_MAX) || (meas_c > div_hi_c);
        too_slow_c = !too_fast_c && (meas_c < div_lo_c);
        code_up_c  = (code == CODE_MAX) ? code : code + CODE_W'(1);
        code_dn_c  = (code == '0) ? code : code - CODE_W'(1);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state    <= IDLE;
            cnt      <= '0;
            code     <= CODE_INIT;
            trim_q   <= TRIM_N'(therm(CODE_INIT));
            lock_cnt <= '0;
            locked_q <= 1'b0;
        end else if (!bus.enable) begin
            // Freeze trim; drop lock and restart through PRIME on re-enable.
            state    <= IDLE;
            cnt      <= '0;
            lock_cnt <= '0;
            locked_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    state <= PRIME;
                end
                PRIME: begin
                    // First window is partial and is discarded.
                    if (ref_rise) begin
                        cnt   <= CNT_W'(1);
                        state <= TRACK;
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end
                TRACK, LOCKED: begin
                    if (ref_rise) begin
                        cnt <= CNT_W'(1);
                        if (too_fast_c) begin
                            code     <= code_up_c;
                            trim_q   <= TRIM_N'(therm(code_up_c));
                            lock_cnt <= '0;
                            locked_q <= 1'b0;
                            state    <= TRACK;
                        end else if (too_slow_c) begin
                            code     <= code_dn_c;
                            trim_q   <= TRIM_N'(therm(code_dn_c));
                            lock_cnt <= '0;
                            locked_q <= 1'b0;
                            state    <= TRACK;
                        end else if (lock_cnt >= LCK_LAST) begin
                            lock_cnt <= LCK_FULL;
                            locked_q <= 1'b1;
                            state    <= LOCKED;
                        end else begin
                            lock_cnt <= lock_cnt + LCK_W'(1);
                        end
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.trim      = trim_q;
    assign bus.trim_code = code;
    assign bus.locked    = locked_q;

endmodule

// File: tb/tb_dco_trim_controller.sv
// Directed bench for dco_trim_controller with a window-level reference model.
module tb_dco_trim_controller;

    logic clock;
    logic resetb;

    dco_trim_if bus ();

    dco_trim_controller dut (
        .clock  (clock),
        .resetb (resetb),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus controls for the reference generator
    int ref_per   = 0;
    int force_per = 0;
    bit dco_mode  = 1'b0;
    bit cmp_en    = 1'b0;

    // Window-level model state
    int     m_code    = 13;
    int     m_lockcnt = 0;
    bit     m_locked  = 1'b0;
    int     m_phase   = 0;     // 0 idle, 1 priming, 2 evaluating
    int     t         = 0;
    int     last_rise = 0;
    bit     prev_ref  = 1'b0;
    int     evq[$];
    bit     ev;
    int     meas;

    logic [25:0] prev_trim;
    bit          prev_ok = 1'b0;
    logic [31:0] exp_trim;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_code(input int c, input int bound, input string name);
        int n = 0;
        while (int'(bus.trim_code) != c && n < bound) begin
            cyc(1);
            n++;
        end
        chk(name, bus.trim_code, c);
    endtask

    task automatic wait_lock(input bit v, input int bound, input string name);
        int n = 0;
        while (bus.locked != v && n < bound) begin
            cyc(1);
            n++;
        end
        chk(name, bus.locked, v);
    endtask

    // DCO cycles per reference period when period = 1.168 + 0.012*code ns
    // and T_ref = 64 * 1.408 ns (the period at code 20), rounded.
    function automatic int dco_cycles(input int code);
        int tp;
        tp = 1168 + 12 * code;
        return (90112 + tp / 2) / tp;
    endfunction

    // Reference generator, synchronous to the bench clock so each window
    // spans a whole number of DCO cycles.
    initial begin
        int per;
        bus.ref_clk = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (ref_per == 0 && !dco_mode) begin
                bus.ref_clk = 1'b0;
            end else begin
                bus.ref_clk = 1'b1;
                repeat (7) begin
                    @(posedge clock);
                    #1;
                end
                bus.ref_clk = 1'b0;
                if (force_per != 0) begin
                    per       = force_per;
                    force_per = 0;
                end else begin
                    per = dco_mode ? dco_cycles(m_code) : ref_per;
                end
                repeat (per - 8) begin
                    @(posedge clock);
                    #1;
                end
            end
        end
    end

    // Reference model: a rising reference edge is judged three clocks after
    // it is first sampled; the window length is the clock distance between
    // consecutive judged edges, saturating at 255.
    always @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            m_code    = 13;
            m_lockcnt = 0;
            m_locked  = 1'b0;
            m_phase   = 0;
            t         = 0;
            last_rise = 0;
            prev_ref  = 1'b0;
            evq.delete();
        end else begin
            ev = (evq.size() > 0) && (evq[0] == t);
            if (ev) void'(evq.pop_front());
            if (!prev_ref && bus.ref_clk) evq.push_back(t + 3);
            prev_ref = bus.ref_clk;

            if (!bus.enable) begin
                m_phase   = 0;
                m_lockcnt = 0;
                m_locked  = 1'b0;
            end else if (m_phase == 0) begin
                m_phase   = 1;
                last_rise = t + 1;
            end else if (ev) begin
                if (m_phase == 1) begin
                    m_phase = 2;
                end else begin
                    meas = (t - last_rise > 255) ? 255 : t - last_rise;
                    if (meas == 255 || meas > int'(bus.div) + 1) begin
                        m_code    = (m_code < 26) ? m_code + 1 : 26;
                        m_lockcnt = 0;
                        m_locked  = 1'b0;
                    end else if (meas < int'(bus.div) - 1) begin
                        m_code    = (m_code > 0) ? m_code - 1 : 0;
                        m_lockcnt = 0;
                        m_locked  = 1'b0;
                    end else begin
                        m_lockcnt = (m_lockcnt < 4) ? m_lockcnt + 1 : 4;
                        if (m_lockcnt == 4) m_locked = 1'b1;
                    end
                end
                last_rise = t;
            end
            t++;
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model
    always @(negedge clock) begin
        if (cmp_en) begin
            exp_trim = (32'd1 << m_code) - 32'd1;
            chk("trim_code", bus.trim_code, m_code);
            chk("locked", bus.locked, m_locked);
            chk("trim", bus.trim, exp_trim[25:0]);
            if (prev_ok && resetb)
                chk("one_bit_step", ($countones(bus.trim ^ prev_trim) <= 1), 1);
            prev_trim = bus.trim;
            prev_ok   = resetb;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb     = 1'b0;
        bus.enable = 1'b0;
        bus.div    = 8'd64;
        cyc(4);
        chk("reset_trim", bus.trim, 26'h0001FFF);
        chk("reset_code", bus.trim_code, 13);
        chk("reset_locked", bus.locked, 0);
        resetb = 1'b1;
        cmp_en = 1'b1;

        // Disabled with the reference running: nothing moves
        ref_per = 70;
        cyc(700);
        chk("idle_trim", bus.trim, 26'h0001FFF);
        chk("idle_code", bus.trim_code, 13);
        chk("idle_locked", bus.locked, 0);

        // Behavioural DCO: converge from 13 to 18 and lock
        dco_mode   = 1'b1;
        bus.enable = 1'b1;
        wait_lock(1'b1, 12 * 70, "dco_lock");
        chk("dco_lock_code", bus.trim_code, 18);
        chk("dco_lock_trim", bus.trim, 26'h003FFFF);

        // One fast window in LOCKED: unlock and step in the same update
        force_per = 69;
        wait_lock(1'b0, 300, "lossy_unlock");
        chk("lossy_code", bus.trim_code, 19);
        wait_lock(1'b1, 6 * 70, "relock");
        chk("relock_code", bus.trim_code, 19);

        // Fixed fast DCO: climbs to 26 and saturates without locking
        dco_mode = 1'b0;
        ref_per  = 70;
        cyc(12 * 70);
        chk("fast_code", bus.trim_code, 26);
        chk("fast_trim", bus.trim, 26'h3FFFFFF);
        chk("fast_locked", bus.locked, 0);

        // div = 0: every window is fast, code stays pinned at 26
        bus.div = 8'd0;
        ref_per = 20;
        cyc(200);
        chk("div0_code", bus.trim_code, 26);

        // Slow DCO: code walks down to 0 and stays there
        bus.div = 8'd200;
        ref_per = 70;
        wait_code(0, 2500, "slow_reach0");
        cyc(300);
        chk("slow_hold0", bus.trim_code, 0);
        chk("slow_trim0", bus.trim, 26'h0);

        // div = 255 with no reference edges: saturated count reads as fast
        bus.div = 8'd255;
        ref_per = 0;
        cyc(400);
        ref_per = 70;
        wait_code(1, 100, "sat_fast");

        // Lock again, then drop enable: trim frozen, lock cleared
        bus.div  = 8'd64;
        dco_mode = 1'b1;
        wait_lock(1'b1, 3000, "relock2");
        chk("relock2_code", bus.trim_code, 18);
        bus.enable = 1'b0;
        cyc(3);
        chk("dis_locked", bus.locked, 0);
        cyc(300);
        chk("dis_code", bus.trim_code, 18);
        chk("dis_trim", bus.trim, 26'h003FFFF);

        // Asynchronous reset mid-window takes effect without a clock edge
        bus.enable = 1'b1;
        cyc(150);
        @(posedge clock);
        #3;
        resetb   = 1'b0;
        ref_per  = 0;
        dco_mode = 1'b0;
        #1;
        chk("async_trim", bus.trim, 26'h0001FFF);
        chk("async_code", bus.trim_code, 13);
        chk("async_locked", bus.locked, 0);
        cyc(80);
        resetb = 1'b1;
        cyc(5);

        // Re-enabled after reset: first window is discarded
        ref_per = 70;
        cyc(40);
        chk("prime_discard", bus.trim_code, 13);
        cyc(70);
        chk("first_eval", bus.trim_code, 14);
        cyc(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dco_trim_controller.md
Name: dco_trim_controller

Overview:
- Digital frequency-locking controller for the 13-stage ring oscillator DCO.
- Counts DCO clock cycles between rising edges of a slow external reference. Compares the count with a programmed divide ratio and steps a 26-bit thermometer trim word up or down until the DCO runs at div × f_ref.
- Sits beside the oscillator. Its clock is the DCO's clockp[0]; its trim output drives the oscillator's trim input.

Parameters:
- CNT_W, 8: width of cycle counter and div input.
- TRIM_N, 26: number of trim bits (thermometer length).
- INIT_CODE, 13: trim code loaded at reset (0..TRIM_N).
- LOCK_TOL, 1: allowed |count − div| for an in-tolerance measurement.
- LOCK_CNT, 4: consecutive in-tolerance measurements required to assert locked.

Ports:
- clock  in  1  DCO output clock (clockp[0]); all logic is on this clock.
- resetb  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = run the loop, 0 = freeze trim.
- ref_clk  in  1  reference clock, asynchronous to clock.
- div  in  CNT_W  target DCO cycles per reference period; quasi-static.
- trim  out  TRIM_N  thermometer trim to the oscillator: trim[i] = (i < code).
- trim_code  out  5  current code, 0..TRIM_N.
- locked  out  1  loop lock indicator.

Behaviour:
- Reset (resetb=0, async): code=INIT_CODE, trim=thermometer(INIT_CODE) (bits 12:0 set), locked=0, counter=0, lock count=0, state=IDLE.
- ref_clk goes through a 2-flop synchronizer and then an edge register. ref_rise is a 1-cycle pulse, 3 clock cycles after the ref edge (±1 for metastability).
- Counter:
  - Increments every cycle, saturating at 2^CNT_W−1.
  - On ref_rise it is captured as meas and reloads to 1.
- States:
  - IDLE: counter held at 0; locked=0; trim held. Moves to PRIME when enable=1.
  - PRIME: counter runs. The first ref_rise (partial window) is discarded, counter reloads, then go to TRACK.
  - TRACK: each ref_rise evaluates meas (see adjust rules).
  - LOCKED: same evaluation as TRACK.
- Adjust rules, applied to the registered outputs one cycle after ref_rise:
  - meas > div+LOCK_TOL (DCO too fast): code+1, saturating at TRIM_N. Lock count cleared.
  - meas < div−LOCK_TOL (DCO too slow): code−1, saturating at 0. Lock count cleared. If div ≤ LOCK_TOL the lower bound is clamped to 0, with no wrap.
  - Otherwise: code unchanged; lock count +1, saturating at LOCK_CNT.
  - A saturated meas (all ones) always counts as too fast.
- Lock:
  - locked=1 and state=LOCKED on the cycle the lock count reaches LOCK_CNT.
  - Any out-of-tolerance measurement in LOCKED gives locked=0 and state=TRACK in the same update in which code steps.
- enable→0 in any state: next cycle state=IDLE, locked=0, lock count=0. Code and trim are frozen at their current value, not reset. Re-enable restarts via PRIME.
- ref_rise and an enable fall in the same cycle: enable wins and no adjustment is made.
- div change while running: takes effect at the next evaluation; no special handling.
- trim is fully registered and glitch-free. Only one bit changes per update.
- Comparisons use CNT_W+1-bit unsigned arithmetic so div+LOCK_TOL does not overflow.

Decomposition:
- Package dco_ctrl_pkg holds:
  - state enum {IDLE, PRIME, TRACK, LOCKED};
  - TRIM_N_DEF=26;
  - function therm(code) returning the TRIM_N thermometer vector.
- One sub-module, ref_edge_sync: 2-flop synchronizer plus rising-edge pulse, with async active-low reset to 0.
- The counter, FSM and trim register live in the top.

Test Plan:
- Reset release: trim=0x0001FFF, trim_code=13, locked=0. With enable=0 and ref toggling, outputs stay unchanged for 10 ref periods.
- Fixed fast DCO: model count 70, div=64. After the PRIME discard, code increments 13→14→…→26 (one step per ref period), then holds at 26; locked stays 0.
- Behavioural DCO model with period rising with code (period=1.168+0.012·code ns), ref period chosen so div is met near code 20, starting from INIT_CODE=13:
  - converges within ≤ 12 evaluations;
  - locked rises after 4 consecutive in-tolerance windows;
  - trim has exactly code ones at all times.
- Lock loss: in LOCKED, force meas=div+5 for one window → locked=0 and code+1 on the same update. Relock requires 4 new in-tolerance windows.
- Boundary cases:
  - div=0 with meas ≥ 2: code saturates at 26, no wrap.
  - div=255 with no ref edges: counter saturates at 255 and the next ref_rise counts as fast.
  - Slow case: code=0 and meas<div gives code stays 0.
- Mid-operation: deassert enable during TRACK → trim frozen, locked=0. Assert resetb=0 asynchronously mid-window → immediate reset values with no clock needed. Re-enable → first window discarded.
